result_wb_control: RTL and testbench

//  AXI4 write master that drains a local result FIFO to DDR: on a start pulse, writes LEN beats from
//  ST_ADDR in INCR bursts of at most MAX_BURST beats, one burst outstanding at a time.

---
 rtl/result_wb_control_pkg.sv | 14 +
 rtl/result_wb_control.sv | 123 ++++++++++++
 tb/tb_result_wb_control.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_wb_control_pkg.sv
// AXI encodings and helpers shared by the DDR read and write paths.
package result_wb_control_pkg;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [3:0] AXI_CACHE_NORMAL = 4'b0011;

    // Number of bits needed to hold value (clogb2(4) == 3).
    function automatic int clogb2(input int value);
        clogb2 = 0;
        for (int v = value; v > 0; v = v >> 1) clogb2++;
    endfunction

endpackage

// File: rtl/result_wb_control.sv
// AXI4 write master draining the result FIFO to DDR in INCR bursts,
// one burst outstanding at a time.
module result_wb_control #(
    parameter int C_AXI_ID_WIDTH   = 10,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int SINGLE_LEN       = 24,
    parameter int MAX_BURST        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_cmptd,
    input  logic                          start,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   st_addr,
    input  logic [SINGLE_LEN-1:0]         len,
    input  logic                          src_empty,
    input  logic [C_AXI_DATA_WIDTH-1:0]   src_data,
    output logic                          src_req,
    output logic [C_AXI_ID_WIDTH-1:0]     axi_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]                    axi_awlen,
    output logic [2:0]                    axi_awsize,
    output logic [1:0]                    axi_awburst,
    output logic                          axi_awlock,
    output logic [3:0]                    axi_awcache,
    output logic [2:0]                    axi_awprot,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                          axi_wlast,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [C_AXI_ID_WIDTH-1:0]     axi_bid,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready,
    output logic                          idle,
    output logic                          done,
    output logic                          err
);
    import result_wb_control_pkg::*;

    localparam int         BYTES  = C_AXI_DATA_WIDTH / 8;
    localparam logic [2:0] AWSIZE = 3'(clogb2(BYTES) - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]                  state;
    logic [C_AXI_ADDR_WIDTH-1:0] addr;
    logic [SINGLE_LEN-1:0]       remaining;
    logic [8:0]                  beat_cnt;
    logic [8:0]                  beats;
    logic                        w_hs;
    logic                        unused_bid;

    // remaining only changes in B, so beats/awlen hold steady through AW and W.
    assign beats = (remaining >= SINGLE_LEN'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(remaining);

    assign axi_awid    = '0;
    assign axi_awaddr  = addr;
    assign axi_awlen   = 8'(beats - 9'd1);
    assign axi_awsize  = AWSIZE;
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_awlock  = 1'b0;
    assign axi_awcache = AXI_CACHE_NORMAL;
    assign axi_awprot  = 3'b000;
    assign axi_awvalid = (state == S_AW);

    // Show-ahead FIFO: the head word goes straight onto the bus, popped on handshake.
    assign axi_wdata  = src_data;
    assign axi_wstrb  = '1;
    assign axi_wvalid = (state == S_W) && !src_empty;
    assign axi_wlast  = (state == S_W) && (beat_cnt == beats - 9'd1);
    assign w_hs       = axi_wvalid && axi_wready;
    assign src_req    = w_hs;

    assign axi_bready = (state == S_B);
    assign idle       = (state == S_IDLE);
    assign done       = (state == S_DONE);
    assign unused_bid = ^axi_bid;

    always_ff @(posedge clk) begin
        if (!rst_n || !init_cmptd) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    addr      <= st_addr;
                    remaining <= len;
                    err       <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= (len == '0) ? S_DONE : S_AW;
                end
                S_AW: if (axi_awready) begin
                    beat_cnt <= '0;
                    state    <= S_W;
                end
                S_W: if (w_hs) begin
                    beat_cnt <= beat_cnt + 9'd1;
                    if (axi_wlast) state <= S_B;
                end
                S_B: if (axi_bvalid) begin
                    if (axi_bresp != AXI_RESP_OKAY) err <= 1'b1;
                    remaining <= remaining - SINGLE_LEN'(beats);
                    addr      <= addr + C_AXI_ADDR_WIDTH'(beats) * C_AXI_ADDR_WIDTH'(BYTES);
                    state     <= (remaining == SINGLE_LEN'(beats)) ? S_DONE : S_AW;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_wb_control.sv
// Bench for result_wb_control: transaction-level job model checked every cycle,
// plus directed jobs with hand-computed expectations.
module tb_result_wb_control;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, init_cmptd = 1'b1, start = 1'b0;
    logic [31:0] st_addr = '0;
    logic [23:0] len = '0;
    logic        src_empty = 1'b1;
    logic [31:0] src_data = '0;
    logic        src_req;
    logic [9:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awlock;
    logic [3:0]  axi_awcache;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid, axi_awready = 1'b0;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast, axi_wvalid, axi_wready = 1'b1;
    logic [9:0]  axi_bid = '0;
    logic [1:0]  axi_bresp = 2'b00;
    logic        axi_bvalid = 1'b0, axi_bready;
    logic        idle, done, err;

    result_wb_control #(
        .C_AXI_ID_WIDTH(10), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32),
        .SINGLE_LEN(24), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_cmptd(init_cmptd), .start(start),
        .st_addr(st_addr), .len(len), .src_empty(src_empty), .src_data(src_data),
        .src_req(src_req), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .idle(idle), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;

    // Bench FIFO (stimulus) and expected write-data order.
    logic [31:0] fifo[$];
    logic [31:0] exp_w[$];
    aw_t         exp_aw[$];

    // Slave/FIFO controls.
    int          aw_stall = 0, aw_wait = 0;
    int          gap_after = -1, gap_len = 0, hold = 0, pops = 0;
    bit          gap_used = 0;
    logic [1:0]  bresp_tab[0:7];
    int          bidx = 0;

    // Per-cycle handshake flags captured at negedge.
    bit aw_hs_f, w_hs_f, wlast_hs_f, b_hs_f, rst_f;

    // Job model.
    bit m_valid = 0, m_busy = 0, m_done = 0, m_err = 0, m_b_pending = 0;
    int m_beats_left = 0, m_bursts_left = 0;

    // Statistics.
    int cyc = 0;
    int n_aw, n_w_hs, n_wlast, n_awv, n_awstall, n_busy_cyc, n_done, n_wgap;
    int start_cyc, done_cyc, wlast_idx, cur_len;
    logic [31:0] aw_addr_log[0:7];
    logic [7:0]  aw_len_log[0:7];
    logic [31:0] last_wdata;
    logic        err_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + model: compare this cycle, then advance the model by this cycle's events.
    always @(negedge clk) begin
        bit exp_wv, exp_awv, nd;
        int rem, b;
        logic [31:0] a;
        aw_t e;
        aw_hs_f    = axi_awvalid && axi_awready;
        w_hs_f     = axi_wvalid && axi_wready;
        wlast_hs_f = w_hs_f && axi_wlast;
        b_hs_f     = axi_bvalid && axi_bready;
        rst_f      = !rst_n || !init_cmptd;

        if (m_valid) begin
            exp_wv  = (m_beats_left > 0) && !src_empty;
            exp_awv = m_busy && !m_done && (m_beats_left == 0) && !m_b_pending && (exp_aw.size() > 0);
            chk("idle", idle, !m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("awvalid", axi_awvalid, exp_awv);
            chk("wvalid", axi_wvalid, exp_wv);
            chk("bready", axi_bready, m_b_pending);
            chk("src_req", src_req, exp_wv && axi_wready);
            chk("consts", {axi_awid, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_wstrb},
                {10'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hF});
            if (exp_awv) begin
                chk("awaddr", axi_awaddr, exp_aw[0].addr);
                chk("awlen", axi_awlen, exp_aw[0].len);
            end
            if (exp_wv && exp_w.size() > 0) begin
                chk("wdata", axi_wdata, exp_w[0]);
                chk("wlast", axi_wlast, m_beats_left == 1);
            end
        end

        if (aw_hs_f && n_aw < 8) begin
            aw_addr_log[n_aw] = axi_awaddr;
            aw_len_log[n_aw]  = axi_awlen;
        end
        if (aw_hs_f) n_aw++;
        if (w_hs_f) begin
            if (axi_wlast) begin n_wlast++; wlast_idx = n_w_hs; end
            last_wdata = axi_wdata;
            n_w_hs++;
        end
        if (n_w_hs > 0 && n_w_hs < cur_len && !axi_wvalid && !axi_awvalid && !axi_bready && !done) n_wgap++;
        if (axi_awvalid) n_awv++;
        if (axi_awvalid && !axi_awready) n_awstall++;
        if (!idle) n_busy_cyc++;
        if (done) begin n_done++; done_cyc = cyc; err_at_done = err; end
        if (rst_f || aw_hs_f) aw_wait = 0;
        else if (axi_awvalid) aw_wait++;

        if (w_hs_f && exp_w.size() > 0) void'(exp_w.pop_front());
        if (rst_f) begin
            m_busy = 0; m_done = 0; m_err = 0; m_b_pending = 0;
            m_beats_left = 0; m_bursts_left = 0;
            exp_aw.delete();
            m_valid = 1;
        end else begin
            nd = 0;
            if (m_done) m_busy = 0;
            else if (!m_busy && start) begin
                m_busy = 1; m_err = 0; start_cyc = cyc;
                rem = int'(len); a = st_addr;
                while (rem > 0) begin
                    b = (rem > MB) ? MB : rem;
                    e.addr = a; e.len = 8'(b - 1);
                    exp_aw.push_back(e);
                    a = a + 32'(b * 4);
                    rem -= b;
                    m_bursts_left++;
                end
                if (len == 0) nd = 1;
            end
            if (aw_hs_f && exp_aw.size() > 0) begin
                m_beats_left = int'(exp_aw[0].len) + 1;
                void'(exp_aw.pop_front());
            end
            if (w_hs_f && m_beats_left > 0) begin
                m_beats_left--;
                if (m_beats_left == 0) m_b_pending = 1;
            end
            if (b_hs_f) begin
                m_b_pending = 0;
                if (axi_bresp != 2'b00) m_err = 1;
                m_bursts_left--;
                if (m_bursts_left == 0) nd = 1;
            end
            m_done = nd;
        end
    end

    // Slave and FIFO driver, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (w_hs_f && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pops++;
            if (pops == gap_after && !gap_used) begin hold = gap_len; gap_used = 1; end
        end else if (hold > 0) hold--;
        src_empty   = (hold > 0) || (fifo.size() == 0);
        src_data    = (fifo.size() > 0) ? fifo[0] : 32'h0;
        axi_awready = (aw_wait >= aw_stall);
        if (rst_f || b_hs_f) begin axi_bvalid = 1'b0; axi_bresp = 2'b00; end
        if (b_hs_f) bidx++;
        if (wlast_hs_f && !rst_f) begin axi_bvalid = 1'b1; axi_bresp = bresp_tab[bidx % 8]; end
    end

    task automatic prep(input int nwords, input logic [31:0] base);
        @(posedge clk); #2;
        fifo.delete(); exp_w.delete();
        for (int i = 0; i < nwords; i++) begin fifo.push_back(base + 32'(i)); exp_w.push_back(base + 32'(i)); end
        aw_stall = 0; gap_after = -1; gap_len = 0; hold = 0; pops = 0; gap_used = 0; bidx = 0;
        for (int i = 0; i < 8; i++) bresp_tab[i] = 2'b00;
        n_aw = 0; n_w_hs = 0; n_wlast = 0; n_awv = 0; n_awstall = 0; n_busy_cyc = 0;
        n_done = 0; n_wgap = 0; wlast_idx = -1; cur_len = nwords;
    endtask

    task automatic run_job(input logic [31:0] a, input int l);
        int d0;
        d0 = n_done;
        @(posedge clk); #1; start = 1'b1; st_addr = a; len = 24'(l);
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 400 && n_done == d0; i++) @(posedge clk);
        chk("job_completes", n_done != d0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) bresp_tab[i] = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {idle, done, err, axi_awvalid, axi_wvalid, axi_bready, src_req}, 7'b1000000);
        rst_n = 1'b1;

        // Empty job: done in the cycle after start, nothing on AW.
        prep(0, 32'h0);
        run_job(32'h2000, 0);
        chk("len0_awvalid_cycles", n_awv, 0);
        chk("len0_done_count", n_done, 1);
        chk("len0_done_latency", done_cyc - start_cyc, 1);
        chk("len0_busy_cycles", n_busy_cyc, 1);

        // 20 beats: 8+8+4 at consecutive 32-byte steps.
        prep(20, 32'hA000_0000);
        run_job(32'h1000, 20);
        chk("len20_aw_count", n_aw, 3);
        chk("len20_aw0", {aw_addr_log[0], aw_len_log[0]}, {32'h1000, 8'd7});
        chk("len20_aw1", {aw_addr_log[1], aw_len_log[1]}, {32'h1020, 8'd7});
        chk("len20_aw2", {aw_addr_log[2], aw_len_log[2]}, {32'h1040, 8'd3});
        chk("len20_pops", n_w_hs, 20);
        chk("len20_fifo_left", fifo.size(), 0);
        chk("len20_done_count", n_done, 1);

        // Single full burst with awready held off for 5 cycles.
        prep(8, 32'hB000_0000);
        aw_stall = 5;
        run_job(32'h3000, 8);
        chk("len8_aw_count", n_aw, 1);
        chk("len8_aw", {aw_addr_log[0], aw_len_log[0]}, {32'h3000, 8'd7});
        chk("len8_aw_stall_cycles", n_awstall, 5);
        chk("len8_wlast_count", n_wlast, 1);

        // FIFO runs dry after 2 words for 4 cycles.
        prep(5, 32'hC000_0000);
        gap_after = 2; gap_len = 4;
        run_job(32'h4000, 5);
        chk("len5_gap_cycles", n_wgap, 4);
        chk("len5_wlast_count", n_wlast, 1);
        chk("len5_wlast_beat", wlast_idx, 4);
        chk("len5_last_word", last_wdata, 32'hC000_0004);

        // SLVERR on first burst; second still issued; err sticky, cleared by next start.
        prep(16, 32'hD000_0000);
        bresp_tab[0] = 2'b10;
        run_job(32'h5000, 16);
        chk("err_aw_count", n_aw, 2);
        chk("err_at_done", err_at_done, 1'b1);
        chk("err_sticky_idle", err, 1'b1);
        prep(8, 32'hD100_0000);
        run_job(32'h6000, 8);
        chk("err_cleared_at_done", err_at_done, 1'b0);

        // Reset mid-W, with starts pulsed while busy and during reset.
        prep(16, 32'hE000_0000);
        @(posedge clk); #1; start = 1'b1; st_addr = 32'h7000; len = 24'd16;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 100 && n_w_hs < 3; i++) @(posedge clk);
        chk("rst_reached_w", n_w_hs >= 3, 1);
        @(posedge clk); #1; start = 1'b1; len = 24'd4;
        @(posedge clk); #1; start = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        chk("rst_outputs", {idle, axi_awvalid, axi_wvalid, axi_bready, src_req}, 5'b10000);
        @(posedge clk); #1; start = 1'b0; rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_aw_count", n_aw, 1);
        chk("rst_no_done", n_done, 0);
        chk("rst_fifo_untouched", fifo.size() + n_w_hs, 16);
        chk("rst_idle_after", idle, 1'b1);

        // Recovery job after reset.
        prep(3, 32'hF000_0000);
        run_job(32'h8000, 3);
        chk("recover_aw", {aw_addr_log[0], aw_len_log[0]}, {32'h8000, 8'd2});
        chk("recover_pops", n_w_hs, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
